des_ram_streamer: RTL and testbench

- Reads a block of 32-bit result words from the 36-bit port of the DES output block RAM and serializes them as 16-bit words to a PipeOut endpoint.
- Sits between the output RAM and the PipeOut; it is the reader for the DES block state machine that writes that RAM.
- A small show-ahead prefetch FIFO means pipe reads never wait on RAM latency.
- Pulses `done` once every requested word has been consumed by the pipe.

---
 rtl/des_ram_streamer.sv | 146 ++++++++++++++
 tb/tb_des_ram_streamer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/des_ram_streamer.sv
// Streams 32-bit words from the DES output RAM to a 16-bit PipeOut through a show-ahead prefetch FIFO.
// Build option: define DES_STREAM_UNDERRUN_EN to compile in the sticky underrun detector.
module des_ram_streamer #(
    parameter int ADDR_W     = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              ti_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_dout,
    input  logic              ep_read,
    output logic [15:0]       ep_datain,
    output logic              busy,
    output logic              done,
    output logic              underrun
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t            state_q;
    logic [ADDR_W:0]   remaining_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_en_q;
    logic              pend_q;
    logic              busy_q;
    logic              done_q;

    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [CW:0]       need_w;
    logic              pop;
    logic              room_ok;

    assign pop     = ep_read && (count_q != '0);
    assign count_d = count_q + (pend_q ? CW'(2) : CW'(0)) - (pop ? CW'(1) : CW'(0));

    // Level after this edge plus the read the RAM samples at this edge
    // (ram_en_q) must leave room for two more entries; this allows one
    // issue every other cycle, matching one 16-bit pop per cycle.
    assign need_w  = {1'b0, count_d} + (ram_en_q ? (CW+1)'(4) : (CW+1)'(2));
    assign room_ok = need_w <= (CW+1)'(FIFO_DEPTH);

    always_ff @(posedge ti_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            ram_addr_q  <= '0;
            ram_en_q    <= 1'b0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ram_en_q <= 1'b0;
            done_q   <= 1'b0;
            pend_q   <= ram_en_q;
            if (ram_en_q)
                ram_addr_q <= ram_addr_q + ADDR_W'(1);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ram_addr_q <= '0;
                        if (word_count == '0) begin
                            remaining_q <= '0;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            ram_en_q    <= 1'b1;
                            busy_q      <= 1'b1;
                            remaining_q <= word_count - (ADDR_W+1)'(1);
                            state_q     <= (word_count == (ADDR_W+1)'(1)) ? S_DRAIN : S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (room_ok) begin
                        ram_en_q    <= 1'b1;
                        remaining_q <= remaining_q - (ADDR_W+1)'(1);
                        if (remaining_q == (ADDR_W+1)'(1))
                            state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!ram_en_q && !pend_q && count_d == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ti_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pend_q)
                wr_ptr_q <= wr_ptr_q + PW'(2);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge ti_clk) begin
        if (pend_q) begin
            mem_q[wr_ptr_q]          <= ram_dout[15:0];
            mem_q[wr_ptr_q + PW'(1)] <= ram_dout[31:16];
        end
    end

`ifdef DES_STREAM_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge ti_clk or negedge reset_n) begin
        if (!reset_n)
            underrun_q <= 1'b0;
        else if (state_q == S_IDLE && start)
            underrun_q <= 1'b0;
        else if (ep_read && count_q == '0)
            underrun_q <= 1'b1;
    end

    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

    assign ep_datain = (count_q == '0) ? 16'h0000 : mem_q[rd_ptr_q];
    assign ram_en    = ram_en_q;
    assign ram_addr  = ram_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_des_ram_streamer.sv
// Scoreboard bench for des_ram_streamer: directed transfers against a behavioural RAM.
module tb_des_ram_streamer;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 8;
`ifdef DES_STREAM_UNDERRUN_EN
    localparam logic UR_EXP = 1'b1;
`else
    localparam logic UR_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   word_count = '0;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_dout = '0;
    logic              ep_read = 1'b0;
    logic [15:0]       ep_datain;
    logic              busy;
    logic              done;
    logic              underrun;

    logic [31:0] ram_mem [1 << ADDR_W];
    logic [15:0] exp_q [$];
    int tests = 0;
    int fails = 0;
    int lvl = 0;
    logic en_prev = 1'b0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int en_cnt = 0;

    des_ram_streamer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .ti_clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .ep_read(ep_read), .ep_datain(ep_datain), .busy(busy), .done(done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ram_en) ram_dout <= ram_mem[ram_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: independent FIFO level model; pops and compares against the scoreboard.
    always @(negedge clk) begin
        if (!reset_n) begin
            lvl     = 0;
            en_prev = 1'b0;
        end else begin
            if (ram_en) begin
                en_cnt++;
                chk("issue_room", (DEPTH - lvl - 2 * int'(en_prev)) >= 2, 1);
            end
            if (lvl == 0)
                chk("empty_head", ep_datain, 16'h0000);
            if (ep_read && lvl > 0) begin
                pop_cnt++;
                if (exp_q.size() == 0)
                    chk("extra_pop", 1, 0);
                else
                    chk("pop_data", ep_datain, exp_q.pop_front());
            end
            if (done) done_cnt++;
            lvl = lvl + (en_prev ? 2 : 0) - ((ep_read && lvl > 0) ? 1 : 0);
            if (lvl > DEPTH) chk("fifo_overflow", lvl, DEPTH);
            en_prev = ram_en;
        end
    end

    // mode 0: ep_read held high; 1: random 30%; 2: two early strobes, gap, then held high
    task automatic run_xfer(input int wc, input int mode);
        int d0, p0, e0, c, budget;
        logic prev_busy, seen;
        d0 = done_cnt; p0 = pop_cnt; e0 = en_cnt;
        budget = 20 * wc + 40;
        @(posedge clk); #1;
        start = 1'b1;
        word_count = (ADDR_W+1)'(wc);
        for (int i = 0; i < wc; i++) begin
            exp_q.push_back(16'h8000 + 16'(i));
            exp_q.push_back(16'h1000 + 16'(i));
        end
        c = 0; seen = 1'b0; prev_busy = 1'b0;
        while (c <= budget) begin
            @(posedge clk); #1;
            start = 1'b0;
            case (mode)
                0:       ep_read = 1'b1;
                1:       ep_read = ($urandom_range(99) < 30);
                default: ep_read = (c < 2) || (c >= 3);
            endcase
            @(negedge clk);
            c++;
            if (c == 1) begin
                chk("busy_after_start", busy, wc > 0);
                chk("first_issue", {ram_en, ram_addr}, {wc > 0, {ADDR_W{1'b0}}});
                chk("underrun_cleared", underrun, 0);
            end
            if (c == 3 && mode == 0 && wc > 0)
                chk("first_word_latency", ep_datain, 16'h8000);
            if (done) begin
                seen = 1'b1;
                chk("busy_at_done", busy, 0);
                if (wc > 0) chk("busy_before_done", prev_busy, 1);
                break;
            end
            prev_busy = busy;
        end
        if (!seen) chk("done_timeout", 0, 1);
        if (wc == 0) chk("zero_done_latency", c <= 2, 1);
        ep_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt - d0, 1);
        chk("pop_count", pop_cnt - p0, 2 * wc);
        chk("read_count", en_cnt - e0, wc);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int p0;
        logic ok;
        for (int i = 0; i < (1 << ADDR_W); i++)
            ram_mem[i] = {16'h1000 + 16'(i), 16'h8000 + 16'(i)};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({ram_en, ram_addr, ep_datain, busy, done, underrun} != '0) ok = 1'b0;
        end
        chk("reset_hold", ok, 1);

        run_xfer(4, 0);
        run_xfer(16, 1);
        run_xfer(2, 2);
        chk("underrun_flag", underrun, UR_EXP);
        run_xfer(0, 0);
        run_xfer(512, 0);
        chk("addr_wrap", ram_addr, 0);

        // Reset in the middle of a 16-word transfer.
        p0 = pop_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        word_count = (ADDR_W+1)'(16);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(16'h8000 + 16'(i));
            exp_q.push_back(16'h1000 + 16'(i));
        end
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (pop_cnt - p0 >= 5) break;
            ep_read = 1'b1;
        end
        chk("mid_pops", pop_cnt - p0, 5);
        reset_n = 1'b0;
        ep_read = 1'b0;
        #2;
        chk("mid_reset_outs", {ram_en, ram_addr, ep_datain, busy, done, underrun}, 0);
        exp_q.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        run_xfer(2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
